// File: rtl/mem_obi_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_obi_lsu_pkg
//  Description : Shared types for the MEM-stage load/store unit: the LSU
//                state encoding, the registered OBI request bundle and the
//                full-word byte-enable constant.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_obi_lsu_pkg;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;

    // Only full-word accesses are issued, so every request enables all lanes.
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2
    } LSU_state;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [3:0]            be;
        logic [OBI_ADDR_W-1:0] addr;
        logic [OBI_DATA_W-1:0] wdata;
    } OBI_req;

endpackage : mem_obi_lsu_pkg
`default_nettype wire

// File: rtl/mem_obi_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_obi_lsu
//  Description : MEM-stage load/store unit of the 5-stage RV32 pipeline.
//                Masters the OBI data port for LW/SW, returns load data to
//                the MEM/WB register and stalls the pipeline while a
//                transaction is outstanding. At most one transaction in
//                flight.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                mem_*_i             - EX/MEM request (valid, we, addr, wdata)
//                flush_i             - squash the MEM-stage instruction
//                data_*              - OBI data-memory master port
//                stall_o             - freeze IF..MEM (combinational)
//                wb_valid_o/wb_rdata_o - load result towards MEM/WB
//                err_o               - misaligned access or bus error pulse
//  Revision    : 1.0  initial release
// ============================================================================
module mem_obi_lsu
    import mem_obi_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32   // only 32 supported
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              flush_i,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    input  logic              data_err_i,
    output logic              stall_o,
    output logic              wb_valid_o,
    output logic [DATA_W-1:0] wb_rdata_o,
    output logic              err_o
);

    LSU_state          r_state;
    OBI_req            r_obi;
    logic              r_kill;
    logic              r_wb_valid;
    logic [DATA_W-1:0] r_wb_rdata;
    logic              r_err;

    logic w_live;
    logic w_accept;
    logic w_misaligned;
    logic w_killed;
    logic w_stall;

    // flush_i outranks mem_valid_i: a flushed instruction never reaches the bus.
    assign w_live       = mem_valid_i && !flush_i;
    assign w_accept     = w_live && (mem_addr_i[1:0] == 2'b00);
    assign w_misaligned = w_live && (mem_addr_i[1:0] != 2'b00);
    // A flush arriving in the very cycle of the response also kills it.
    assign w_killed     = r_kill || flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LSU_IDLE;
            r_obi      <= '0;
            r_kill     <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_rdata <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                LSU_IDLE: begin
                    if (w_accept) begin
                        r_obi.req   <= 1'b1;
                        r_obi.we    <= mem_we_i;
                        r_obi.be    <= BE_WORD;
                        r_obi.addr  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                        r_obi.wdata <= mem_wdata_i;
                        r_kill      <= 1'b0;
                        r_state     <= LSU_REQ;
                    end else if (w_misaligned) begin
                        r_err <= 1'b1;
                    end
                end
                LSU_REQ: begin
                    // Request fields are frozen until the grant; an early
                    // rvalid here is illegal OBI and deliberately ignored.
                    if (flush_i) begin
                        r_kill <= 1'b1;
                    end
                    if (data_gnt_i) begin
                        r_obi.req <= 1'b0;
                        r_obi.be  <= '0;
                        r_state   <= LSU_RESP;
                    end
                end
                LSU_RESP: begin
                    if (flush_i) begin
                        r_kill <= 1'b1;
                    end
                    if (data_rvalid_i) begin
                        r_state <= LSU_IDLE;
                        if (!w_killed) begin
                            if (data_err_i) begin
                                r_err <= 1'b1;
                            end else if (!r_obi.we) begin
                                r_wb_valid <= 1'b1;
                                r_wb_rdata <= data_rdata_i;
                            end
                        end
                    end
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

    // Stall drops in the rvalid cycle so the pipeline advances exactly at
    // completion and the next instruction is seen in IDLE one cycle later.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            LSU_IDLE: w_stall = w_accept;
            LSU_REQ:  w_stall = 1'b1;
            LSU_RESP: w_stall = !data_rvalid_i;
            default:  w_stall = 1'b0;
        endcase
    end

    assign data_req_o   = r_obi.req;
    assign data_addr_o  = r_obi.addr;
    assign data_we_o    = r_obi.we;
    assign data_be_o    = r_obi.be;
    assign data_wdata_o = r_obi.wdata;
    assign stall_o      = w_stall;
    assign wb_valid_o   = r_wb_valid;
    assign wb_rdata_o   = r_wb_rdata;
    assign err_o        = r_err;

endmodule : mem_obi_lsu
`default_nettype wire

// File: tb/tb_mem_obi_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_obi_lsu
//  Description : Self-checking bench for mem_obi_lsu: directed vector table,
//                hand-written multi-cycle sequences (delayed grant, reset in
//                REQ) and a randomized run against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_obi_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i, mem_we_i, flush_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i, data_err_i;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;
    logic        stall_o, wb_valid_o, err_o;
    logic [31:0] wb_rdata_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_obi_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid_i  (mem_valid_i),
        .mem_we_i     (mem_we_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .flush_i      (flush_i),
        .data_req_o   (data_req_o),
        .data_gnt_i   (data_gnt_i),
        .data_addr_o  (data_addr_o),
        .data_we_o    (data_we_o),
        .data_be_o    (data_be_o),
        .data_wdata_o (data_wdata_o),
        .data_rvalid_i(data_rvalid_i),
        .data_rdata_i (data_rdata_i),
        .data_err_i   (data_err_i),
        .stall_o      (stall_o),
        .wb_valid_o   (wb_valid_o),
        .wb_rdata_o   (wb_rdata_o),
        .err_o        (err_o)
    );

    typedef struct {
        logic        rst, valid, we, flush, gnt, rvalid, derr;
        logic [31:0] addr, wdata, rdata;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        e_req, e_stall, e_wbv, e_err, e_we;
        logic [31:0] e_addr, e_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input stim_t s);
        rst           = s.rst;
        mem_valid_i   = s.valid;
        mem_we_i      = s.we;
        mem_addr_i    = s.addr;
        mem_wdata_i   = s.wdata;
        flush_i       = s.flush;
        data_gnt_i    = s.gnt;
        data_rvalid_i = s.rvalid;
        data_rdata_i  = s.rdata;
        data_err_i    = s.derr;
    endtask

    // Inputs change at negedge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic stim_t S(logic v, logic we, logic [31:0] a, logic [31:0] wd,
                                logic fl, logic g, logic rv, logic [31:0] rd, logic de);
        stim_t s;
        s.rst = 1'b0; s.valid = v; s.we = we; s.addr = a; s.wdata = wd;
        s.flush = fl; s.gnt = g; s.rvalid = rv; s.rdata = rd; s.derr = de;
        return s;
    endfunction

    function automatic vec_t V(stim_t s, logic req, logic st, logic wbv, logic er,
                               logic [31:0] ea, logic ewe, logic [31:0] erd);
        vec_t v;
        v.s = s; v.e_req = req; v.e_stall = st; v.e_wbv = wbv; v.e_err = er;
        v.e_addr = ea; v.e_we = ewe; v.e_rdata = erd;
        return v;
    endfunction

    // Transaction-level reference: one optional outstanding access.
    logic        m_busy, m_granted, m_kill, m_we;
    logic [31:0] m_addr, m_wdata;
    logic        m_wbv, m_err;
    logic [31:0] m_rdata;

    task automatic model_reset();
        m_busy = 0; m_granted = 0; m_kill = 0; m_we = 0;
        m_addr = 0; m_wdata = 0; m_wbv = 0; m_err = 0; m_rdata = 0;
    endtask

    function automatic logic model_stall(stim_t s);
        if (m_busy) return !(m_granted && s.rvalid);
        return s.valid && !s.flush && (s.addr[1:0] == 2'b00);
    endfunction

    task automatic model_edge(input stim_t s);
        if (s.rst) begin
            model_reset();
            return;
        end
        m_wbv = 0;
        m_err = 0;
        if (!m_busy) begin
            if (s.valid && !s.flush) begin
                if (s.addr[1:0] != 2'b00) begin
                    m_err = 1;
                end else begin
                    m_busy = 1; m_granted = 0; m_kill = 0;
                    m_we = s.we; m_addr = s.addr & ~32'h3; m_wdata = s.wdata;
                end
            end
        end else begin
            if (s.flush) m_kill = 1;
            if (!m_granted) begin
                if (s.gnt) m_granted = 1;
            end else if (s.rvalid) begin
                m_busy = 0;
                if (!m_kill) begin
                    if (s.derr) m_err = 1;
                    else if (!m_we) begin m_wbv = 1; m_rdata = s.rdata; end
                end
            end
        end
    endtask

    task automatic check_model(input stim_t s, input string tag);
        logic exp_req;
        exp_req = m_busy && !m_granted;
        chk({tag, " req"},   data_req_o, exp_req);
        chk({tag, " stall"}, stall_o,    model_stall(s));
        chk({tag, " wbv"},   wb_valid_o, m_wbv);
        chk({tag, " err"},   err_o,      m_err);
        chk({tag, " rdata"}, wb_rdata_o, m_rdata);
        if (exp_req) begin
            chk({tag, " addr"},  data_addr_o,  m_addr);
            chk({tag, " we"},    data_we_o,    m_we);
            chk({tag, " wdata"}, data_wdata_o, m_wdata);
            chk({tag, " be"},    data_be_o,    4'hF);
        end
    endtask

    vec_t  tbl[$];
    stim_t idle_s;

    initial begin
        idle_s = S(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- reset ----------------
        apply(idle_s);
        rst = 1'b1;
        @(negedge clk);
        next_cycle();
        apply(idle_s);
        #1;
        chk("reset req",   data_req_o,   0);
        chk("reset be",    data_be_o,    0);
        chk("reset addr",  data_addr_o,  0);
        chk("reset we",    data_we_o,    0);
        chk("reset wdata", data_wdata_o, 0);
        chk("reset stall", stall_o,      0);
        chk("reset wbv",   wb_valid_o,   0);
        chk("reset rdata", wb_rdata_o,   0);
        chk("reset err",   err_o,        0);
        next_cycle();

        // ---------------- directed table ----------------
        // LW 0x100, immediate grant, data next cycle
        tbl.push_back(V(S(1,0,32'h100,0,0,0,0,0,0),            0,1,0,0, 0,        0, 0));
        tbl.push_back(V(S(1,0,32'h100,0,0,1,0,0,0),            1,1,0,0, 32'h100,  0, 0));
        tbl.push_back(V(S(1,0,32'h100,0,0,0,1,32'hDEADBEEF,0), 0,0,0,0, 0,        0, 0));
        tbl.push_back(V(S(0,0,0,0,0,0,0,0,0),                  0,0,1,0, 0,        0, 32'hDEADBEEF));
        // LW 0x102 misaligned
        tbl.push_back(V(S(1,0,32'h102,0,0,0,0,0,0),            0,0,0,0, 0,        0, 32'hDEADBEEF));
        tbl.push_back(V(S(0,0,0,0,0,0,0,0,0),                  0,0,0,1, 0,        0, 32'hDEADBEEF));
        tbl.push_back(V(S(0,0,0,0,0,0,0,0,0),                  0,0,0,0, 0,        0, 32'hDEADBEEF));
        // LW 0x300 bus error, then LW 0x304 right behind it
        tbl.push_back(V(S(1,0,32'h300,0,0,0,0,0,0),            0,1,0,0, 0,        0, 32'hDEADBEEF));
        tbl.push_back(V(S(1,0,32'h300,0,0,1,0,0,0),            1,1,0,0, 32'h300,  0, 32'hDEADBEEF));
        tbl.push_back(V(S(1,0,32'h300,0,0,0,1,32'h11111111,1), 0,0,0,0, 0,        0, 32'hDEADBEEF));
        tbl.push_back(V(S(1,0,32'h304,0,0,0,0,0,0),            0,1,0,1, 0,        0, 32'hDEADBEEF));
        tbl.push_back(V(S(1,0,32'h304,0,0,1,0,0,0),            1,1,0,0, 32'h304,  0, 32'hDEADBEEF));
        tbl.push_back(V(S(1,0,32'h304,0,0,0,1,32'h0BADF00D,0), 0,0,0,0, 0,        0, 32'hDEADBEEF));
        tbl.push_back(V(S(0,0,0,0,0,0,0,0,0),                  0,0,1,0, 0,        0, 32'h0BADF00D));
        // LW 0x400 flushed during RESP: completes on the bus, no writeback
        tbl.push_back(V(S(1,0,32'h400,0,0,0,0,0,0),            0,1,0,0, 0,        0, 32'h0BADF00D));
        tbl.push_back(V(S(1,0,32'h400,0,0,1,0,0,0),            1,1,0,0, 32'h400,  0, 32'h0BADF00D));
        tbl.push_back(V(S(1,0,32'h400,0,1,0,0,0,0),            0,1,0,0, 0,        0, 32'h0BADF00D));
        tbl.push_back(V(S(0,0,0,0,0,0,1,32'hAAAA5555,0),       0,0,0,0, 0,        0, 32'h0BADF00D));
        tbl.push_back(V(S(0,0,0,0,0,0,0,0,0),                  0,0,0,0, 0,        0, 32'h0BADF00D));
        // flush outranks valid: misaligned and aligned both dropped silently
        tbl.push_back(V(S(1,0,32'h501,0,1,0,0,0,0),            0,0,0,0, 0,        0, 32'h0BADF00D));
        tbl.push_back(V(S(1,1,32'h600,0,1,0,0,0,0),            0,0,0,0, 0,        0, 32'h0BADF00D));
        tbl.push_back(V(S(0,0,0,0,0,0,0,0,0),                  0,0,0,0, 0,        0, 32'h0BADF00D));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].s);
            #1;
            chk($sformatf("vec%0d req", i),   data_req_o, tbl[i].e_req);
            chk($sformatf("vec%0d stall", i), stall_o,    tbl[i].e_stall);
            chk($sformatf("vec%0d wbv", i),   wb_valid_o, tbl[i].e_wbv);
            chk($sformatf("vec%0d err", i),   err_o,      tbl[i].e_err);
            chk($sformatf("vec%0d rdata", i), wb_rdata_o, tbl[i].e_rdata);
            if (tbl[i].e_req) begin
                chk($sformatf("vec%0d addr", i), data_addr_o, tbl[i].e_addr);
                chk($sformatf("vec%0d we", i),   data_we_o,   tbl[i].e_we);
                chk($sformatf("vec%0d be", i),   data_be_o,   4'hF);
            end
            next_cycle();
        end

        // ---------------- SW 0x204 with 4-cycle grant delay ----------------
        apply(S(1, 1, 32'h204, 32'h12345678, 0, 0, 0, 0, 0));
        #1;
        chk("sw accept stall", stall_o, 1);
        chk("sw accept req",   data_req_o, 0);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            // Upstream fields wander; the bus must still show the latched request.
            apply(S(1, 0, $urandom, $urandom, 0, (i == 4), 0, 0, 0));
            #1;
            chk($sformatf("sw req c%0d", i),   data_req_o,   1);
            chk($sformatf("sw addr c%0d", i),  data_addr_o,  32'h204);
            chk($sformatf("sw we c%0d", i),    data_we_o,    1);
            chk($sformatf("sw wdata c%0d", i), data_wdata_o, 32'h12345678);
            chk($sformatf("sw be c%0d", i),    data_be_o,    4'hF);
            chk($sformatf("sw stall c%0d", i), stall_o,      1);
            next_cycle();
        end
        apply(S(1, 1, 32'h204, 32'h12345678, 0, 0, 0, 0, 0));
        #1;
        chk("sw resp wait stall", stall_o,    1);
        chk("sw resp wait req",   data_req_o, 0);
        next_cycle();
        apply(S(1, 1, 32'h204, 32'h12345678, 0, 0, 1, 32'hFFFFFFFF, 0));
        #1;
        chk("sw rvalid stall", stall_o, 0);
        next_cycle();
        apply(idle_s);
        #1;
        chk("sw no wbv",      wb_valid_o, 0);
        chk("sw no err",      err_o,      0);
        chk("sw rdata held",  wb_rdata_o, 32'h0BADF00D);
        next_cycle();

        // ---------------- reset while in REQ ----------------
        apply(S(1, 0, 32'h700, 0, 0, 0, 0, 0, 0));
        next_cycle();
        apply(S(1, 0, 32'h700, 0, 0, 0, 0, 0, 0));
        #1;
        chk("rstreq pre req", data_req_o, 1);
        rst = 1'b1;
        next_cycle();
        apply(idle_s);
        #1;
        chk("rstreq req",   data_req_o,   0);
        chk("rstreq stall", stall_o,      0);
        chk("rstreq be",    data_be_o,    0);
        chk("rstreq addr",  data_addr_o,  0);
        chk("rstreq wbv",   wb_valid_o,   0);
        chk("rstreq err",   err_o,        0);
        chk("rstreq rdata", wb_rdata_o,   0);
        next_cycle();
        apply(idle_s);
        #1;
        chk("rstreq stays idle", data_req_o, 0);

        // ---------------- randomized run vs reference model ----------------
        begin
            stim_t s;
            logic  hold;
            s = idle_s;
            s.rst = 1'b1;
            apply(s);
            next_cycle();
            model_reset();
            hold = 0;
            s = idle_s;
            for (int c = 0; c < 4000; c++) begin
                if (!hold) begin
                    s.valid = ($urandom_range(0, 3) != 0);
                    s.we    = $urandom_range(0, 1);
                    s.addr  = $urandom & ~32'h3;
                    if ($urandom_range(0, 5) == 0) s.addr[1:0] = 2'($urandom_range(1, 3));
                    s.wdata = $urandom;
                end
                s.rst    = ($urandom_range(0, 199) == 0);
                s.flush  = ($urandom_range(0, 9) == 0);
                s.gnt    = m_busy && !m_granted && ($urandom_range(0, 2) != 0);
                s.rvalid = m_busy && (m_granted ? ($urandom_range(0, 1) == 1)
                                                : ($urandom_range(0, 7) == 0));
                s.rdata  = $urandom;
                s.derr   = ($urandom_range(0, 7) == 0);
                apply(s);
                #1;
                check_model(s, $sformatf("rnd%0d", c));
                hold = model_stall(s) && !s.rst;
                @(posedge clk);
                model_edge(s);
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_obi_lsu
`default_nettype wire
